// File: rtl/uart_prog_loader.sv
// Writable instruction RAM filled from an 8N1 UART program stream (A5, N, 4N data bytes, XOR checksum).
// The CPU fetches combinationally through RD_ADDR/RD_DATA and is held in reset while a load is in flight.
module uart_prog_loader #(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_W       = 8,
  parameter int TIMEOUT_CLKS = 5000000
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              RX,
  input  logic [ADDR_W-1:0] RD_ADDR,
  output logic [31:0]       RD_DATA,
  output logic              CPU_HOLD,
  output logic              LOAD_DONE,
  output logic              LOAD_ERR,
  output logic [ADDR_W:0]   WORDS_LOADED
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam int TO_W = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CLKS - 1);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_COUNT = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_CSUM  = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;

  logic             rx_p0, rx_p1, rx_p2;
  logic [1:0]       rx_state;
  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       rx_shift;
  logic             byte_valid, frame_err;

  logic [2:0]       state;
  logic [7:0]       n_words, word_idx;
  logic [1:0]       byte_idx;
  logic [TO_W-1:0]  to_cnt;
  logic [7:0]       csum_acc;
  logic [31:0]      asm_word;
  logic             fsm_active, timeout;

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  // Stage p0/p1: synchronizer; p2 holds the previous sample for falling-edge detection
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
      rx_p2 <= 1'b1;
    end else begin
      rx_p0 <= RX;
      rx_p1 <= rx_p0;
      rx_p2 <= rx_p1;
    end
  end

  // Receiver: start bit re-checked at mid-bit, data LSB first, single stop-bit sample
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rx_state   <= RX_IDLE;
      clk_cnt    <= '0;
      bit_idx    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_p2 && !rx_p1) begin
            rx_state <= RX_START;
            clk_cnt  <= '0;
          end
        end
        RX_START: begin
          if (clk_cnt == HALF_LAST) begin
            clk_cnt  <= '0;
            bit_idx  <= '0;
            rx_state <= rx_p1 ? RX_IDLE : RX_DATA;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt <= '0;
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) rx_state <= RX_STOP;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt    <= '0;
            byte_valid <= rx_p1;
            frame_err  <= !rx_p1;
            rx_state   <= RX_IDLE;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (rx_state == RX_DATA && clk_cnt == BIT_LAST) rx_shift <= {rx_p1, rx_shift[7:1]};
  end

  assign fsm_active = (state == S_COUNT) || (state == S_DATA) || (state == S_CSUM);
  // A byte arriving in the expiry cycle takes precedence over the timeout
  assign timeout    = fsm_active && !byte_valid && (to_cnt == TO_LAST);

  // Loader FSM: control state only, data path registers below carry no reset
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state        <= S_IDLE;
      n_words      <= '0;
      word_idx     <= '0;
      byte_idx     <= '0;
      to_cnt       <= TO_W'(1);
      CPU_HOLD     <= 1'b0;
      LOAD_DONE    <= 1'b0;
      LOAD_ERR     <= 1'b0;
      WORDS_LOADED <= '0;
    end else begin
      LOAD_DONE <= 1'b0;
      if (!fsm_active || byte_valid) to_cnt <= TO_W'(1);
      else if (to_cnt != TO_LAST)    to_cnt <= to_cnt + 1'b1;

      if (fsm_active && (frame_err || timeout)) begin
        state    <= S_ERR;
        LOAD_ERR <= 1'b1;
      end else if (byte_valid) begin
        case (state)
          S_IDLE, S_ERR: begin
            if (rx_shift == 8'hA5) begin
              state        <= S_COUNT;
              CPU_HOLD     <= 1'b1;
              LOAD_ERR     <= 1'b0;
              WORDS_LOADED <= '0;
            end
          end
          S_COUNT: begin
            if (rx_shift == 8'h00) begin
              state    <= S_ERR;
              LOAD_ERR <= 1'b1;
            end else begin
              n_words  <= rx_shift;
              word_idx <= '0;
              byte_idx <= '0;
              state    <= S_DATA;
            end
          end
          S_DATA: begin
            byte_idx <= byte_idx + 1'b1;
            if (byte_idx == 2'd3) begin
              word_idx     <= word_idx + 1'b1;
              WORDS_LOADED <= WORDS_LOADED + 1'b1;
              if (word_idx == n_words - 8'd1) state <= S_CSUM;
            end
          end
          S_CSUM: begin
            if (rx_shift == csum_acc) begin
              LOAD_DONE <= 1'b1;
              CPU_HOLD  <= 1'b0;
              state     <= S_IDLE;
            end else begin
              state    <= S_ERR;
              LOAD_ERR <= 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // Word assembly, checksum and RAM write share the byte_valid cycle
  always_ff @(posedge CLK) begin
    if (byte_valid && state == S_COUNT) begin
      csum_acc <= 8'h00;
    end else if (byte_valid && state == S_DATA) begin
      csum_acc <= csum_acc ^ rx_shift;
      asm_word <= {asm_word[23:0], rx_shift};
      if (byte_idx == 2'd3) mem[ADDR_W'(word_idx)] <= {asm_word[23:0], rx_shift};
    end
  end

  assign RD_DATA = mem[RD_ADDR];

endmodule

// File: tb/tb_uart_prog_loader.sv
// Bench for uart_prog_loader: a frame-level model driven by the byte stream, checked every cycle,
// plus literal expectations for the directed loads, errors, timeout and reset scenarios.
module tb_uart_prog_loader;
  localparam int CPB = 8;
  localparam int AW  = 8;
  localparam int TO  = 2000;
  // start edge to visible effect: 2 sync + 1 edge + 4 half bit + 64 data + 8 stop + 1 FSM
  localparam int LAT = 80;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          RX = 1'b1;
  logic [AW-1:0] RD_ADDR = '0;
  logic [31:0]   RD_DATA;
  logic          CPU_HOLD, LOAD_DONE, LOAD_ERR;
  logic [AW:0]   WORDS_LOADED;

  uart_prog_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW), .TIMEOUT_CLKS(TO)) dut (
    .CLK(CLK), .RESET(RESET), .RX(RX), .RD_ADDR(RD_ADDR), .RD_DATA(RD_DATA),
    .CPU_HOLD(CPU_HOLD), .LOAD_DONE(LOAD_DONE), .LOAD_ERR(LOAD_ERR), .WORDS_LOADED(WORDS_LOADED)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // byte events posted by the sender, consumed by the model
  logic [7:0] ev_b   [0:255];
  bit         ev_ok  [0:255];
  int         ev_due [0:255];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  int         last_start = 0;
  int         frame_start = 0;
  logic [7:0] tx_q[$];
  int         rd_sel = -1;

  // model state
  bit          m_in_frame = 0, m_hold = 0, m_err = 0, m_done = 0;
  int          m_words = 0;
  int          m_last_bv = 0;
  logic [7:0]  m_frame[$];
  logic [31:0] exp_mem [0:255];
  bit          known   [0:255];

  // observed edges
  int hold_rise_cyc = -1, hold_fall_cyc = -1, err_rise_cyc = -1, err_fall_cyc = -1;
  int done_cyc = -1, done_count = 0;
  logic prev_hold = 1'b0, prev_err = 1'b0;

  task automatic model_fail();
    m_in_frame = 0;
    m_err      = 1;
    m_hold     = 1;
  endtask

  task automatic apply_byte(input logic [7:0] b, input bit ok);
    int n, sz, idx;
    logic [7:0] x;
    if (!ok) begin
      if (m_in_frame) model_fail();
      return;
    end
    m_last_bv = cyc - 1;
    if (!m_in_frame) begin
      if (b == 8'hA5) begin
        m_in_frame = 1;
        m_frame.delete();
        m_hold  = 1;
        m_err   = 0;
        m_words = 0;
      end
      return;
    end
    m_frame.push_back(b);
    sz = m_frame.size();
    n  = int'(m_frame[0]);
    if (n == 0) begin
      model_fail();
      return;
    end
    if (sz <= 1 + 4 * n) begin
      if (sz > 1 && (sz - 1) % 4 == 0) begin
        idx = ((sz - 1) / 4 - 1) % 256;
        exp_mem[idx] = {m_frame[sz-4], m_frame[sz-3], m_frame[sz-2], m_frame[sz-1]};
        known[idx]   = 1;
        m_words++;
      end
    end else begin
      x = 8'h00;
      for (int i = 1; i <= 4 * n; i++) x = x ^ m_frame[i];
      if (b == x) begin
        m_done     = 1;
        m_hold     = 0;
        m_in_frame = 0;
      end else begin
        model_fail();
      end
    end
  endtask

  always @(negedge CLK) begin
    bit applied;
    applied = 0;
    m_done  = 0;
    if (!RESET) begin
      m_in_frame = 0;
      m_hold     = 0;
      m_err      = 0;
      m_words    = 0;
      m_frame.delete();
      rd_ptr = wr_ptr;
    end else begin
      while (rd_ptr < wr_ptr && ev_due[rd_ptr] <= cyc) begin
        apply_byte(ev_b[rd_ptr], ev_ok[rd_ptr]);
        rd_ptr++;
        applied = 1;
      end
      if (!applied && m_in_frame && cyc == m_last_bv + TO) model_fail();
    end
    check("cyc_hold",  CPU_HOLD,     m_hold);
    check("cyc_done",  LOAD_DONE,    m_done);
    check("cyc_err",   LOAD_ERR,     m_err);
    check("cyc_words", WORDS_LOADED, m_words);
    if (known[RD_ADDR]) check("cyc_rd_data", RD_DATA, exp_mem[RD_ADDR]);
    if (CPU_HOLD && !prev_hold) hold_rise_cyc = cyc;
    if (!CPU_HOLD && prev_hold) hold_fall_cyc = cyc;
    if (LOAD_ERR && !prev_err)  err_rise_cyc  = cyc;
    if (!LOAD_ERR && prev_err)  err_fall_cyc  = cyc;
    if (LOAD_DONE) begin
      done_count++;
      done_cyc = cyc;
    end
    prev_hold = CPU_HOLD;
    prev_err  = LOAD_ERR;
  end

  // fetch address: scans words 0..3 unless a specific word is requested
  initial begin
    forever begin
      @(posedge CLK);
      #2;
      if (rd_sel >= 0) RD_ADDR = AW'(rd_sel);
      else             RD_ADDR = (RD_ADDR + 1'b1) & 8'h03;
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit stop);
    @(posedge CLK);
    #1;
    RX = 1'b0;
    last_start     = cyc;
    ev_b[wr_ptr]   = b;
    ev_ok[wr_ptr]  = stop;
    ev_due[wr_ptr] = cyc + LAT;
    wr_ptr++;
    repeat (CPB) @(posedge CLK);
    for (int i = 0; i < 8; i++) begin
      #1 RX = b[i];
      repeat (CPB) @(posedge CLK);
    end
    #1 RX = stop;
    repeat (CPB - 1) @(posedge CLK);
    if (!stop) begin
      @(posedge CLK);
      #1 RX = 1'b1;
      repeat (CPB) @(posedge CLK);
    end
  endtask

  task automatic send_frame();
    for (int i = 0; i < tx_q.size(); i++) begin
      send_byte(tx_q[i], 1'b1);
      if (i == 0) frame_start = last_start;
    end
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge CLK);
    #2;
  endtask

  task automatic read_check(input int addr, input logic [31:0] exp, input string name);
    rd_sel = addr;
    @(posedge CLK);
    #3;
    check(name, RD_DATA, exp);
    rd_sel = -1;
  endtask

  initial begin
    int waited;
    #1 RESET = 1'b0;
    #1;
    check("rst_hold",  CPU_HOLD,     1'b0);
    check("rst_done",  LOAD_DONE,    1'b0);
    check("rst_err",   LOAD_ERR,     1'b0);
    check("rst_words", WORDS_LOADED, 0);
    repeat (3) @(posedge CLK);
    #1 RESET = 1'b1;
    settle(4);

    // good two-word load
    tx_q = '{8'hA5, 8'h02, 8'h00, 8'h01, 8'h00, 8'h05, 8'h01, 8'h02, 8'h01, 8'h00, 8'h06};
    send_frame();
    settle(3);
    check("good_hold_rise", hold_rise_cyc, frame_start + LAT);
    check("good_hold_fall", hold_fall_cyc, last_start + LAT);
    check("good_done_cyc",  done_cyc,      last_start + LAT);
    check("good_done_cnt",  done_count,    1);
    check("good_words",     WORDS_LOADED,  2);
    check("good_hold_now",  CPU_HOLD,      1'b0);
    read_check(0, 32'h00010005, "good_mem0");
    read_check(1, 32'h01020100, "good_mem1");

    // same frame with a bad checksum
    tx_q = '{8'hA5, 8'h02, 8'h00, 8'h01, 8'h00, 8'h05, 8'h01, 8'h02, 8'h01, 8'h00, 8'h07};
    send_frame();
    settle(3);
    check("bad_err",      LOAD_ERR,     1'b1);
    check("bad_hold",     CPU_HOLD,     1'b1);
    check("bad_err_cyc",  err_rise_cyc, last_start + LAT);
    check("bad_done_cnt", done_count,   1);
    check("bad_words",    WORDS_LOADED, 2);
    read_check(1, 32'h01020100, "bad_mem1");

    // recovery from ERR with a single-word frame
    tx_q = '{8'hA5, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
    send_frame();
    settle(3);
    check("rec_err_clear", err_fall_cyc, frame_start + LAT);
    check("rec_err",       LOAD_ERR,     1'b0);
    check("rec_hold",      CPU_HOLD,     1'b0);
    check("rec_done_cnt",  done_count,   2);
    check("rec_words",     WORDS_LOADED, 1);
    read_check(0, 32'hDEADBEEF, "rec_mem0");

    // 2-clock glitch while idle
    @(posedge CLK);
    #1 RX = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RX = 1'b1;
    settle(100);
    check("gl_hold",     CPU_HOLD,     1'b0);
    check("gl_err",      LOAD_ERR,     1'b0);
    check("gl_words",    WORDS_LOADED, 1);
    check("gl_done_cnt", done_count,   2);

    // zero stop bit during DATA
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b0);
    settle(3);
    check("fe_err",     LOAD_ERR,     1'b1);
    check("fe_hold",    CPU_HOLD,     1'b1);
    check("fe_words",   WORDS_LOADED, 0);
    check("fe_err_cyc", err_rise_cyc, ev_due[wr_ptr-1]);

    // timeout after A5 03 00
    tx_q = '{8'hA5, 8'h03, 8'h00};
    send_frame();
    waited = 0;
    while (!LOAD_ERR && waited < TO + 400) begin
      @(posedge CLK);
      waited++;
    end
    settle(2);
    check("to_err_cyc", err_rise_cyc, last_start + LAT - 1 + TO);
    check("to_err",     LOAD_ERR,     1'b1);
    check("to_words",   WORDS_LOADED, 0);
    check("to_hold",    CPU_HOLD,     1'b1);

    // reset after two data bytes
    tx_q = '{8'hA5, 8'h01, 8'h11, 8'h22};
    send_frame();
    settle(2);
    check("mid_hold_before", CPU_HOLD, 1'b1);
    RESET = 1'b0;
    #1;
    check("mr_hold",  CPU_HOLD,     1'b0);
    check("mr_done",  LOAD_DONE,    1'b0);
    check("mr_err",   LOAD_ERR,     1'b0);
    check("mr_words", WORDS_LOADED, 0);
    read_check(0, 32'hDEADBEEF, "mr_mem0");
    #1 RESET = 1'b1;
    settle(4);

    tx_q = '{8'hA5, 8'h02, 8'h00, 8'h01, 8'h00, 8'h05, 8'h01, 8'h02, 8'h01, 8'h00, 8'h06};
    send_frame();
    settle(3);
    check("fresh_done_cnt", done_count,   3);
    check("fresh_words",    WORDS_LOADED, 2);
    check("fresh_hold",     CPU_HOLD,     1'b0);
    check("fresh_err",      LOAD_ERR,     1'b0);
    read_check(0, 32'h00010005, "fresh_mem0");
    read_check(1, 32'h01020100, "fresh_mem1");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual still running, required finish before 2000000");
    $fatal(1, "watchdog expired");
  end

endmodule
